// File: rtl/rect_motion_ctrl.sv
// rect_motion_ctrl: game sequencer for the VGA rectangle datapath.
// Runs the IDLE/RUN/PAUSE game FSM from the board buttons and moves a
// BOX_W x BOX_H rectangle once per frame, bouncing it off the visible-area
// edges. Corner outputs feed vga_game.
// Optional feature: define RECT_BOUNCE_CNT_EN to add the saturating
// bounce_cnt[15:0] output.
module rect_motion_ctrl #(
    parameter int H_VIS = 1024,
    parameter int V_VIS = 768,
    parameter int BOX_W = 600,
    parameter int BOX_H = 200,
    parameter int X0    = 200,
    parameter int Y0    = 200,
    parameter int STEP  = 4
) (
    input  logic        clk_65M,
    input  logic        clear,
    input  logic        game_on,
    input  logic        game_start,
    input  logic [16:0] H_cnt,
    input  logic [16:0] V_cnt,
    output logic [19:0] x1,
    output logic [19:0] x2,
    output logic [19:0] y1,
    output logic [19:0] y2,
    output logic [1:0]  state,
`ifdef RECT_BOUNCE_CNT_EN
    output logic        hit,
    output logic [15:0] bounce_cnt
`else
    output logic        hit
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    localparam logic [16:0] H_TICK = 17'(H_VIS);
    localparam logic [16:0] V_TICK = 17'(V_VIS);
    localparam logic [19:0] H_LIM  = 20'(H_VIS);
    localparam logic [19:0] V_LIM  = 20'(V_VIS);
    localparam logic [19:0] W_BOX  = 20'(BOX_W);
    localparam logic [19:0] H_BOX  = 20'(BOX_H);
    localparam logic [19:0] X_HOME = 20'(X0);
    localparam logic [19:0] Y_HOME = 20'(Y0);
    localparam logic [19:0] D_STEP = 20'(STEP);

    // One axis of motion: returns {bounce, new_dir, new_pos}. The clamps
    // land the box exactly on the edge, so the subtraction never underflows.
    function automatic logic [21:0] axis_step(input logic [19:0] pos,
                                              input logic        dir,
                                              input logic [19:0] box,
                                              input logic [19:0] lim);
        logic [21:0] res;
        if (!dir) begin
            if (pos + box + D_STEP >= lim) res = {1'b1, 1'b1, lim - box};
            else                           res = {1'b0, 1'b0, pos + D_STEP};
        end else begin
            if (pos <= D_STEP) res = {1'b1, 1'b0, 20'd0};
            else               res = {1'b0, 1'b1, pos - D_STEP};
        end
        return res;
    endfunction

    // Saturating increment for the bounce counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic        on_p0, on_p1;
    logic        start_p0, start_p1, start_p2;
    logic        game_on_s, start_rise, frame_tick;
    state_t      state_q, state_d;
    logic [19:0] px, py;
    logic        dx, dy;
    logic        hit_q;
    logic [21:0] x_res, y_res;

    assign game_on_s  = on_p1;
    assign start_rise = start_p1 & ~start_p2;
    assign frame_tick = (H_cnt == H_TICK) && (V_cnt == V_TICK);
    assign x_res      = axis_step(px, dx, W_BOX, H_LIM);
    assign y_res      = axis_step(py, dy, H_BOX, V_LIM);

    // Two-flop synchronizers for the board inputs, plus edge history for start.
    always_ff @(posedge clk_65M or negedge clear) begin
        if (!clear) begin
            on_p0    <= 1'b0;
            on_p1    <= 1'b0;
            start_p0 <= 1'b0;
            start_p1 <= 1'b0;
            start_p2 <= 1'b0;
        end else begin
            on_p0    <= game_on;
            on_p1    <= on_p0;
            start_p0 <= game_start;
            start_p1 <= start_p0;
            start_p2 <= start_p1;
        end
    end

    // Game state register.
    always_ff @(posedge clk_65M or negedge clear) begin
        if (!clear) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; losing game_on overrides any start press.
    always_comb begin
        state_d = state_q;
        if (!game_on_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_rise) state_d = RUN;
                RUN:     if (start_rise) state_d = PAUSE;
                PAUSE:   if (start_rise) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Position/direction update; motion uses the pre-transition state, while
    // dropping game_on sends the box home on the very next edge.
    always_ff @(posedge clk_65M or negedge clear) begin
        if (!clear) begin
            px    <= X_HOME;
            py    <= Y_HOME;
            dx    <= 1'b0;
            dy    <= 1'b0;
            hit_q <= 1'b0;
        end else if (!game_on_s || state_q == IDLE) begin
            px    <= X_HOME;
            py    <= Y_HOME;
            dx    <= 1'b0;
            dy    <= 1'b0;
            hit_q <= 1'b0;
        end else if (state_q == RUN && frame_tick) begin
            px    <= x_res[19:0];
            dx    <= x_res[20];
            py    <= y_res[19:0];
            dy    <= y_res[20];
            hit_q <= x_res[21] | y_res[21];
        end else begin
            hit_q <= 1'b0;
        end
    end

`ifdef RECT_BOUNCE_CNT_EN
    logic [15:0] bounce_cnt_q;

    // Saturating count of bounce pulses, cleared whenever the game is idle.
    always_ff @(posedge clk_65M or negedge clear) begin
        if (!clear)                bounce_cnt_q <= 16'd0;
        else if (state_q == IDLE)  bounce_cnt_q <= 16'd0;
        else if (hit_q)            bounce_cnt_q <= sat_inc16(bounce_cnt_q);
    end

    assign bounce_cnt = bounce_cnt_q;
`endif

    assign x1    = px;
    assign x2    = px + W_BOX;
    assign y1    = py;
    assign y2    = py + H_BOX;
    assign state = state_q;
    assign hit   = hit_q;

endmodule

// File: doc/rect_motion_ctrl.md
# rect_motion_ctrl

Game sequencer for the VGA rectangle datapath. Runs the IDLE/RUN/PAUSE game state machine from the `game_on` / `game_start` board inputs. Once per frame it computes the rectangle corners `x1`, `x2`, `y1`, `y2` that feed `vga_game`, replacing the constant coordinates. The rectangle bounces inside the 1024x768 visible area. It sits between `vga_ctrl` (counters) and `vga_game` (pixel colouring) in the 65 MHz domain.

## Interface
Parameters:
- H_VIS, 1024, visible pixels per line
- V_VIS, 768, visible lines per frame
- BOX_W, 600, rectangle width (x2-x1)
- BOX_H, 200, rectangle height (y2-y1)
- X0, 200, home x1
- Y0, 200, home y1
- STEP, 4, pixels moved per axis per frame (1..BOX_W-1)

Ports:
- clk_65M  in  1  pixel clock
- clear  in  1  reset, asynchronous assert, active-low
- game_on  in  1  asynchronous level: game enabled
- game_start  in  1  asynchronous button: start/pause toggle
- H_cnt  in  17  horizontal counter from vga_ctrl
- V_cnt  in  17  vertical counter from vga_ctrl
- x1, x2, y1, y2  out  20 each  rectangle corners, registered
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE
- hit  out  1  one-cycle pulse when any edge bounce occurs

## Operation
- Input conditioning:
  - `game_on` and `game_start` each pass through a 2-FF synchronizer.
  - `start_rise` = synchronized `game_start` high AND its previous sample low.
- Frame tick: `frame_tick` = (H_cnt == H_VIS) && (V_cnt == V_VIS). This is one cycle per frame, in blanking, so the corners never change during active video.
- State machine transitions, evaluated every cycle:
  - Any state with `game_on_s` = 0 -> IDLE. This has priority over everything else.
  - IDLE: `start_rise` with `game_on_s` = 1 -> RUN.
  - RUN: `start_rise` -> PAUSE.
  - PAUSE: `start_rise` -> RUN.
- Position registers: `px` and `py` (20 bits, top-left corner) and direction bits `dx` and `dy` (0 = increasing).
- Outputs: x1=px, x2=px+BOX_W, y1=py, y2=py+BOX_H.
- IDLE: px=X0, py=Y0, dx=dy=0. These are forced every cycle while in IDLE.
- RUN, on `frame_tick`, per axis (x shown; y identical with BOX_H and V_VIS):
  - dx=0 and px+BOX_W+STEP >= H_VIS: px = H_VIS-BOX_W, dx=1, bounce.
  - dx=1 and px <= STEP: px = 0, dx=0, bounce.
  - Otherwise px ± STEP.
- PAUSE: position and directions hold.
- `hit` pulses for one cycle, the cycle after a `frame_tick` in which either axis bounced. A corner hit (both axes in the same frame) produces a single pulse.
- All arithmetic is unsigned 20-bit. No underflow is possible because of the clamps.

## Timing
- Reset values (clear low): state=IDLE, x1=X0, x2=X0+BOX_W, y1=Y0, y2=Y0+BOX_H, hit=0, dx=dy=0. Synchronizer flops are 0.
- Button latency: `game_start` rising at the pin -> `start_rise` 3 clocks later at most -> `state` updates on the next edge.
- Motion latency: the corners update on the clock edge after the `frame_tick` cycle, i.e. one cycle after the tick.
- `start_rise` and `frame_tick` in the same cycle: the motion step uses the current (pre-transition) state.
  - IDLE->RUN does not move the box this frame.
  - RUN->PAUSE still moves the box this frame.
- `game_on` dropping mid-frame: IDLE and the home position appear on the next clock edge, not at the next frame.
- `clear` asserted mid-operation: all registers return to reset values immediately. On release, the first update occurs at the next `frame_tick`.
- Holding `game_start` high produces exactly one `start_rise`. There is no debounce; the board input is debounced externally.

## Configuration
- `RECT_BOUNCE_CNT_EN` defined: adds output `bounce_cnt` [15:0].
  - Increments on every `hit` and saturates at 16'hFFFF.
  - Cleared on reset and whenever state is IDLE.
- `RECT_BOUNCE_CNT_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset / release:
  - Stimulus: `clear` low, then high.
  - Required: x1=200, x2=800, y1=200, y2=400, state=00, hit=0, all held with no ticks.
- Start and move:
  - Stimulus: game_on=1, pulse game_start, then 3 frame ticks.
  - Required: state=01 within 4 clocks; after the ticks x1=212, x2=812, y1=212, y2=412.
- Right-edge bounce:
  - Stimulus: RUN from home.
  - Required: after 56 ticks x1=424, x2=1024, dx=1, one `hit` pulse; the next tick gives x1=420.
- Pause:
  - Stimulus: pulse game_start, 10 ticks, pulse game_start again.
  - Required: corners are constant during PAUSE; state goes 10 then 01, and motion resumes in the same direction.
- Abort, with simultaneous start:
  - Stimulus: drop game_on mid-RUN, with a start_rise in the same cycle.
  - Required: state=00 and corners back at home within 3 clocks of the sync delay; start is ignored.
- Counter (with `RECT_BOUNCE_CNT_EN`):
  - Stimulus: force bounce_cnt near FFFF, then more bounces.
  - Required: each bounce increments the count, it saturates at FFFF, and returning to IDLE clears it to 0.
